frequency_result_writer: RTL and testbench

Downstream stage of the frequency analyzer manager: snapshots the six 32-bit action-time results (three pixels × two frequencies) when a measurement stops. It then streams them, one register per slot, into the AXI slave register-write port (register_operation / register_number / register_write). On completion it raises the interrupt that tells software the result registers are valid.

---
 rtl/frequency_result_writer.sv | 219 +++++++++++++++++++++
 tb/tb_frequency_result_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : frequency_result_writer                                        |
// | Purpose : Snapshots the six action-time results (3 pixels x 2            |
// |           frequencies) on the rising edge of stop, then streams them     |
// |           into the AXI slave register-write port, one register per       |
// |           WRITE/GAP slot pair, and raises irq once all are written.      |
// | Ports   : s00_axi_aclk      - sole clock                                 |
// |           s00_axi_aresetn   - asynchronous active-low reset              |
// |           stop              - measurement stop, rising edge = capture    |
// |           clear             - synchronous abort / interrupt acknowledge  |
// |           results           - packed results, result k at [W*k +: W]     |
// |           register_operation- 0 = none, 2 = write                        |
// |           register_number   - target register (FIRST_REGISTER + k)       |
// |           register_write    - write data                                 |
// |           busy              - write sequence in progress                 |
// |           irq               - level interrupt, results written           |
// |           overrun           - sticky, stop edge seen while busy          |
// | Options : FREQUENCY_RESULT_STATUS_EN - appends a status write            |
// |           {capture sequence number[15:0], NUMBER_OF_RESULTS[15:0]} to    |
// |           register FIRST_REGISTER + NUMBER_OF_RESULTS.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module frequency_result_writer #(
  parameter int NUMBER_OF_RESULTS     = 6,
  parameter int RESULT_WIDTH          = 32,
  parameter int FIRST_REGISTER        = 1,
  parameter int REGISTER_NUMBER_WIDTH = 8
) (
  input  logic                                      s00_axi_aclk,
  input  logic                                      s00_axi_aresetn,
  input  logic                                      stop,
  input  logic                                      clear,
  input  logic [NUMBER_OF_RESULTS*RESULT_WIDTH-1:0] results,
  output logic [1:0]                                register_operation,
  output logic [REGISTER_NUMBER_WIDTH-1:0]          register_number,
  output logic [RESULT_WIDTH-1:0]                   register_write,
  output logic                                      busy,
  output logic                                      irq,
  output logic                                      overrun
);

`ifdef FREQUENCY_RESULT_STATUS_EN
  localparam int c_NUMBER_OF_WRITES = NUMBER_OF_RESULTS + 1;
`else
  localparam int c_NUMBER_OF_WRITES = NUMBER_OF_RESULTS;
`endif
  localparam int c_INDEX_WIDTH = $clog2(c_NUMBER_OF_WRITES + 1);
  localparam logic [c_INDEX_WIDTH-1:0] c_LAST_INDEX = c_INDEX_WIDTH'(c_NUMBER_OF_WRITES - 1);
  localparam logic [1:0] c_OP_NONE  = 2'd0;
  localparam logic [1:0] c_OP_WRITE = 2'd2;
  localparam logic [REGISTER_NUMBER_WIDTH-1:0] c_FIRST_REGISTER =
    REGISTER_NUMBER_WIDTH'(FIRST_REGISTER);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_next_state;
  logic                             r_stop_d;
  logic                             w_stop_edge;
  logic                             w_capture;
  logic [c_INDEX_WIDTH-1:0]         r_index;
  logic [c_INDEX_WIDTH-1:0]         w_next_index;
  logic [c_INDEX_WIDTH-1:0]         w_index_inc;
  logic [RESULT_WIDTH-1:0]          r_snapshot [NUMBER_OF_RESULTS];
  logic [RESULT_WIDTH-1:0]          w_inc_data;

  logic [1:0]                       r_operation;
  logic [REGISTER_NUMBER_WIDTH-1:0] r_number;
  logic [RESULT_WIDTH-1:0]          r_write;
  logic                             r_busy;
  logic                             r_irq;
  logic                             r_overrun;

  logic [1:0]                       w_next_operation;
  logic [REGISTER_NUMBER_WIDTH-1:0] w_next_number;
  logic [RESULT_WIDTH-1:0]          w_next_write;
  logic                             w_next_overrun;

`ifdef FREQUENCY_RESULT_STATUS_EN
  logic [15:0]                      r_seq_num;
`endif

  assign w_stop_edge = stop & ~r_stop_d;
  assign w_index_inc = r_index + c_INDEX_WIDTH'(1);

  // Data for the slot that follows the current one. Outputs are registered,
  // so the value is selected one cycle ahead from the snapshot.
  always_comb begin
    w_inc_data = '0;
    for (int k = 0; k < NUMBER_OF_RESULTS; k++) begin
      if (w_index_inc == c_INDEX_WIDTH'(k)) begin
        w_inc_data = r_snapshot[k];
      end
    end
`ifdef FREQUENCY_RESULT_STATUS_EN
    if (w_index_inc == c_INDEX_WIDTH'(NUMBER_OF_RESULTS)) begin
      // r_seq_num was already bumped at the capture edge of this sequence.
      w_inc_data = RESULT_WIDTH'({r_seq_num, 16'(NUMBER_OF_RESULTS)});
    end
`endif
  end

  // Next-state and next-output logic. The register outputs are computed for
  // the state being entered so that they appear right after the active edge.
  always_comb begin
    w_next_state     = r_state;
    w_next_index     = r_index;
    w_next_operation = c_OP_NONE;
    w_next_number    = '0;
    w_next_write     = '0;
    w_next_overrun   = r_overrun;
    w_capture        = 1'b0;

    if (clear) begin
      // clear wins over a coincident stop edge, which is dropped.
      w_next_state   = ST_IDLE;
      w_next_overrun = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stop_edge) begin
            w_capture        = 1'b1;
            w_next_index     = '0;
            w_next_state     = ST_WRITE;
            w_next_operation = c_OP_WRITE;
            w_next_number    = c_FIRST_REGISTER;
            // Snapshot is loaded on this same edge, so slot 0 comes straight
            // from the input bus.
            w_next_write     = results[RESULT_WIDTH-1:0];
          end
        end
        ST_WRITE: begin
          if (w_stop_edge) w_next_overrun = 1'b1;
          w_next_state = ST_GAP;
        end
        ST_GAP: begin
          if (w_stop_edge) w_next_overrun = 1'b1;
          if (r_index == c_LAST_INDEX) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_index     = w_index_inc;
            w_next_state     = ST_WRITE;
            w_next_operation = c_OP_WRITE;
            w_next_number    = c_FIRST_REGISTER + REGISTER_NUMBER_WIDTH'(w_index_inc);
            w_next_write     = w_inc_data;
          end
        end
        ST_DONE: begin
          if (!stop) w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_stop_d    <= 1'b0;
      r_operation <= c_OP_NONE;
      r_number    <= '0;
      r_write     <= '0;
      r_busy      <= 1'b0;
      r_irq       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_index     <= w_next_index;
      r_stop_d    <= stop;
      r_operation <= w_next_operation;
      r_number    <= w_next_number;
      r_write     <= w_next_write;
      r_busy      <= (w_next_state == ST_WRITE) || (w_next_state == ST_GAP);
      r_irq       <= (w_next_state == ST_DONE);
      r_overrun   <= w_next_overrun;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int k = 0; k < NUMBER_OF_RESULTS; k++) begin
        r_snapshot[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < NUMBER_OF_RESULTS; k++) begin
        r_snapshot[k] <= results[RESULT_WIDTH*k +: RESULT_WIDTH];
      end
    end
  end

`ifdef FREQUENCY_RESULT_STATUS_EN
  // Capture counter survives clear; only reset returns it to zero.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_seq_num <= '0;
    end else if (w_capture) begin
      r_seq_num <= r_seq_num + 16'd1;
    end
  end
`endif

  assign register_operation = r_operation;
  assign register_number    = r_number;
  assign register_write     = r_write;
  assign busy               = r_busy;
  assign irq                = r_irq;
  assign overrun            = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frequency_result_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_frequency_result_writer                                     |
// | Purpose : Self-checking bench for frequency_result_writer. A directed    |
// |           table of input rows with hand-written expectations, random     |
// |           stop/clear/results traffic, and an asynchronous-reset          |
// |           sequence, all compared every cycle against a cycle-count       |
// |           reference model. Honours FREQUENCY_RESULT_STATUS_EN.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_frequency_result_writer;

  localparam int NR    = 6;
  localparam int RW    = 32;
  localparam int FIRST = 1;
  localparam int RNW   = 8;
`ifdef FREQUENCY_RESULT_STATUS_EN
  localparam int NW = NR + 1;
`else
  localparam int NW = NR;
`endif
  localparam int SEQ = 2 * NW;

  logic             s00_axi_aclk = 1'b0;
  logic             s00_axi_aresetn;
  logic             stop;
  logic             clear;
  logic [NR*RW-1:0] results;
  logic [1:0]       register_operation;
  logic [RNW-1:0]   register_number;
  logic [RW-1:0]    register_write;
  logic             busy;
  logic             irq;
  logic             overrun;

  frequency_result_writer #(
    .NUMBER_OF_RESULTS    (NR),
    .RESULT_WIDTH         (RW),
    .FIRST_REGISTER       (FIRST),
    .REGISTER_NUMBER_WIDTH(RNW)
  ) dut (
    .s00_axi_aclk      (s00_axi_aclk),
    .s00_axi_aresetn   (s00_axi_aresetn),
    .stop              (stop),
    .clear             (clear),
    .results           (results),
    .register_operation(register_operation),
    .register_number   (register_number),
    .register_write    (register_write),
    .busy              (busy),
    .irq               (irq),
    .overrun           (overrun)
  );

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycles elapsed since the accepted capture (-1 = idle).
  int          m_phase;
  bit          m_done;
  bit          m_ovr;
  bit          m_stop_d;
  int          m_seq;
  logic [RW-1:0] m_snap [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase  = -1;
    m_done   = 1'b0;
    m_ovr    = 1'b0;
    m_stop_d = 1'b0;
    m_seq    = 0;
    for (int k = 0; k < NR; k++) m_snap[k] = '0;
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = stop && !m_stop_d;
    if (clear) begin
      m_phase = -1;
      m_done  = 1'b0;
      m_ovr   = 1'b0;
    end else if (m_done) begin
      if (!stop) m_done = 1'b0;
    end else if (m_phase >= 0) begin
      if (edge_seen) m_ovr = 1'b1;
      m_phase++;
      if (m_phase == SEQ) begin
        m_phase = -1;
        m_done  = 1'b1;
      end
    end else if (edge_seen) begin
      for (int k = 0; k < NR; k++) m_snap[k] = results[RW*k +: RW];
      m_phase = 0;
      m_seq   = (m_seq + 1) % 65536;
    end
    m_stop_d = stop;
  endtask

  task automatic compare_model(input string tag);
    logic [1:0]     e_op;
    logic [RNW-1:0] e_num;
    logic [RW-1:0]  e_wr;
    int             slot;
    e_op  = 2'd0;
    e_num = '0;
    e_wr  = '0;
    if (m_phase >= 0 && (m_phase % 2) == 0) begin
      slot  = m_phase / 2;
      e_op  = 2'd2;
      e_num = RNW'(FIRST + slot);
      if (slot < NR) e_wr = m_snap[slot];
      else           e_wr = RW'({m_seq[15:0], 16'(NR)});
    end
    check({tag, "_op"},      64'(register_operation), 64'(e_op));
    check({tag, "_num"},     64'(register_number),    64'(e_num));
    check({tag, "_data"},    64'(register_write),     64'(e_wr));
    check({tag, "_busy"},    64'(busy),               64'(m_phase >= 0));
    check({tag, "_irq"},     64'(irq),                64'(m_done));
    check({tag, "_overrun"}, 64'(overrun),            64'(m_ovr));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_op"},      64'(register_operation), 64'd0);
    check({tag, "_num"},     64'(register_number),    64'd0);
    check({tag, "_data"},    64'(register_write),     64'd0);
    check({tag, "_busy"},    64'(busy),               64'd0);
    check({tag, "_irq"},     64'(irq),                64'd0);
    check({tag, "_overrun"}, 64'(overrun),            64'd0);
  endtask

  // One clock: drive inputs at the falling edge, let the model and DUT take
  // the rising edge, then compare 1 time unit later.
  task automatic apply(input logic s, input logic c, input logic chg, input string tag);
    @(negedge s00_axi_aclk);
    stop  = s;
    clear = c;
    if (chg) for (int k = 0; k < NR; k++) results[RW*k +: RW] = RW'($urandom);
    @(posedge s00_axi_aclk);
    model_step();
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    int   cycles;
    logic stop;
    logic clear;
    logic change;
    logic exp_busy;
    logic exp_irq;
    logic exp_overrun;
  } row_t;

  row_t rows [19];
  int   writes_seen;

  initial begin
    // cycles, stop, clear, change results, then busy/irq/overrun after the row
    rows[0]  = '{1,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
    rows[1]  = '{1,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // capture at N
    rows[2]  = '{3,       1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // results change after N
    rows[3]  = '{1,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[4]  = '{1,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // second edge -> overrun
    rows[5]  = '{SEQ - 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // still busy at N+SEQ-1
    rows[6]  = '{1,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // DONE at N+SEQ
    rows[7]  = '{2,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // irq holds while stop high
    rows[8]  = '{1,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // stop low -> irq drops
    rows[9]  = '{1,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // clear overrun
    rows[10] = '{1,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // capture at M
    rows[11] = '{4,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[12] = '{1,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // clear at M+5
    rows[13] = '{SEQ,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // no edge, no irq
    rows[14] = '{1,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[15] = '{1,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // restart
    rows[16] = '{SEQ - 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[17] = '{1,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rows[18] = '{1,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // clear from DONE

    s00_axi_aresetn = 1'b0;
    stop            = 1'b0;
    clear           = 1'b0;
    for (int k = 0; k < NR; k++) results[RW*k +: RW] = RW'(k + 1) * 32'h1111_1111;
    model_reset();
    repeat (2) @(posedge s00_axi_aclk);
    #1;
    check_zero("reset");
    @(posedge s00_axi_aclk);
    #2;
    s00_axi_aresetn = 1'b1;

    // Directed table.
    for (int r = 0; r < 19; r++) begin
      for (int c = 0; c < rows[r].cycles; c++) begin
        apply(rows[r].stop, rows[r].clear, rows[r].change, $sformatf("row%0d", r));
      end
      check($sformatf("row%0d_tbl_busy", r),    64'(busy),    64'(rows[r].exp_busy));
      check($sformatf("row%0d_tbl_irq", r),     64'(irq),     64'(rows[r].exp_irq));
      check($sformatf("row%0d_tbl_overrun", r), 64'(overrun), 64'(rows[r].exp_overrun));
    end

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic s;
      s = stop;
      if ($urandom_range(0, 7) == 0) s = ~s;
      apply(s, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), "rand");
    end

    // Asynchronous reset in the middle of a sequence.
    apply(1'b0, 1'b0, 1'b1, "pre_rst");
    apply(1'b1, 1'b0, 1'b0, "rst_cap");
    repeat (6) apply(1'b1, 1'b0, 1'b0, "rst_run");
    #3;
    s00_axi_aresetn = 1'b0;
    stop            = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge s00_axi_aclk);
    #2;
    s00_axi_aresetn = 1'b1;

    apply(1'b0, 1'b0, 1'b1, "post_rst");
    writes_seen = 0;
    for (int i = 0; i < SEQ + 2; i++) begin
      apply(1'b1, 1'b0, 1'b0, "post_seq");
      if (register_operation == 2'd2) writes_seen++;
    end
    check("post_rst_write_count", 64'(writes_seen), 64'(NW));
    check("post_rst_irq", 64'(irq), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
